sensor_frame_collector: RTL
===========================

// Module: sensor_frame_collector
// PURPOSE
//  Producer end of the drop unit's sensor interface: deframes a serial byte
//  stream from the sensor bus into four stable 8-bit readings (sensor1..4).
//  Outputs update atomically on a validated frame only; otherwise previous
//  values are held. Sits between the sensor link and the baggage_drop logic.
// PARAMETERS
//  HEADER   8'hA5  frame start marker, hunted for in IDLE
//  TIMEOUT  1000   max clk cycles between accepted bytes inside a frame
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  byte_in      in   8  serial byte from sensor link
//  byte_valid   in   1  byte_in valid
//  byte_ready   out  1  collector accepts byte; transfer = valid & ready
//  hold         in   1  downstream busy; stalls acceptance
//  sensor1      out  8  reading 1 (first data byte of frame)
//  sensor2      out  8  reading 2
//  sensor3      out  8  reading 3
//  sensor4      out  8  reading 4
//  frame_valid  out  1  1-cycle pulse, sensor1..4 just updated
//  frame_err    out  1  1-cycle pulse, frame dropped (checksum/timeout)
//  frame_cnt    out  8  count of good frames, wraps 255->0
// BEHAVIOUR
//  - Reset: state IDLE; sensor1..4=0, frame_valid=0, frame_err=0,
//    frame_cnt=0, byte_ready=0, timeout counter=0, shadow regs=0.
//  - byte_ready = ~hold when out of reset (registered; 0 in reset).
//  - FSM: IDLE -> D1 -> D2 -> D3 -> D4 -> [CHK] -> IDLE; advance only on an
//    accepted byte. IDLE: byte==HEADER -> D1; any other byte dropped silently.
//  - D1..D4: byte stored in shadow reg 1..4; HEADER value in data treated as
//    plain data (no resync).
//  - Commit: on last byte of frame, next cycle sensor1..4 <= shadow,
//    frame_valid=1, frame_cnt+1. Latency last byte accepted -> outputs = 1 clk.
//  - Timeout: counter (>= clog2(TIMEOUT+1) bits) cleared on every accepted
//    byte and in IDLE, increments each clk in D1..CHK (also while hold=1).
//    Reaching TIMEOUT -> IDLE, frame_err pulse, outputs unchanged.
//    Byte accepted in same cycle as expiry: byte wins, counter clears.
//  - Error path never changes sensor1..4 or frame_cnt.
//  - Back-to-back frames: HEADER may be accepted the cycle after commit.
//  - frame_valid and frame_err never high in the same cycle.
//  - rst asserted mid-frame: immediate return to reset state, partial
//    frame discarded.
// CONFIGURATION
//  SENSOR_CHECKSUM_EN defined: frame = HEADER, 4 data, checksum byte; CHK
//    state compares byte to XOR of the 4 data bytes; match -> commit,
//    mismatch -> frame_err pulse, IDLE, no update.
//  Undefined: frame = HEADER + 4 data; commit directly after D4; no CHK
//    state; frame_err driven only by timeout.
// TESTING
//  - Good frame A5,10,20,30,40[,40 if CHK] -> 1 clk later sensor1..4 =
//    10,20,30,40, frame_valid 1 cycle, frame_cnt=1.
//  - CHK_EN: A5,01,02,03,04,FF -> frame_err pulse, sensors keep previous
//    values, frame_cnt unchanged; next good frame accepted normally.
//  - Garbage 00,11,A4 then good frame -> only good frame committed, no err.
//  - A5,10 then idle TIMEOUT clks -> frame_err at expiry, IDLE; byte landing
//    on expiry cycle instead -> frame continues.
//  - hold=1 during D2 for 50 clks -> byte_ready=0, nothing accepted;
//    release -> frame completes; rst mid-frame -> all outputs 0.
//  - 256 good frames -> frame_cnt wraps to 0; A5 inside data byte kept as data.

Source files
------------

// File: rtl/sensor_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_collector
// Description : Deframes a serial byte stream from the sensor link into four
//               8-bit readings. A frame is the HEADER byte followed by four
//               data bytes (plus an XOR checksum byte when
//               SENSOR_CHECKSUM_EN is defined). The readings update together,
//               and only when a frame validates. An inter-byte timeout drops
//               frames that stall.
// Config      : `define SENSOR_CHECKSUM_EN to add the checksum byte and the
//               CHK state. When it is undefined, frames commit straight after
//               the fourth data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_collector #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       hold,
  output logic [7:0] sensor1,
  output logic [7:0] sensor2,
  output logic [7:0] sensor3,
  output logic [7:0] sensor4,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  // The timer must be able to hold the value TIMEOUT itself.
  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  // The timer expires on the clock where it would step up to TIMEOUT.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D1   = 3'd1,
    S_D2   = 3'd2,
    S_D3   = 3'd3,
    S_D4   = 3'd4
`ifdef SENSOR_CHECKSUM_EN
    , S_CHK = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       shd1_q, shd2_q, shd3_q, shd4_q;
  logic [7:0]       shd1_d, shd2_d, shd3_d, shd4_d;
  logic [7:0]       sens1_q, sens2_q, sens3_q, sens4_q;
  logic [7:0]       sens1_d, sens2_d, sens3_d, sens4_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic             fe_q, fe_d;
  logic             accept;

  // A byte transfers only when the registered ready flag and valid are both high.
  assign accept = byte_valid & ready_q;

  // Next-state logic: frame sequencing, inter-byte timer, shadow capture and commit.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    shd1_d  = shd1_q;
    shd2_d  = shd2_q;
    shd3_d  = shd3_q;
    shd4_d  = shd4_q;
    sens1_d = sens1_q;
    sens2_d = sens2_q;
    sens3_d = sens3_q;
    sens4_d = sens4_q;
    cnt_d   = cnt_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;

    if (state_q == S_IDLE) begin
      // Hunt for the header. Any other byte is consumed and dropped silently.
      tmr_d = '0;
      if (accept && (byte_in == HEADER)) begin
        state_d = S_D1;
      end
    end else if (accept) begin
      // An accepted byte always restarts the timer, even on the expiry cycle.
      tmr_d = '0;
      case (state_q)
        S_D1: begin
          shd1_d  = byte_in;
          state_d = S_D2;
        end
        S_D2: begin
          shd2_d  = byte_in;
          state_d = S_D3;
        end
        S_D3: begin
          shd3_d  = byte_in;
          state_d = S_D4;
        end
        S_D4: begin
          shd4_d  = byte_in;
`ifdef SENSOR_CHECKSUM_EN
          state_d = S_CHK;
`else
          // Last data byte: the fourth reading comes straight from the input.
          state_d = S_IDLE;
          sens1_d = shd1_q;
          sens2_d = shd2_q;
          sens3_d = shd3_q;
          sens4_d = byte_in;
          fv_d    = 1'b1;
          cnt_d   = cnt_q + 8'd1;
`endif
        end
`ifdef SENSOR_CHECKSUM_EN
        S_CHK: begin
          state_d = S_IDLE;
          if (byte_in == (shd1_q ^ shd2_q ^ shd3_q ^ shd4_q)) begin
            sens1_d = shd1_q;
            sens2_d = shd2_q;
            sens3_d = shd3_q;
            sens4_d = shd4_q;
            fv_d    = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            fe_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (tmr_q == TMR_LAST) begin
      // The stall has lasted TIMEOUT clocks. Abandon the frame and leave the
      // outputs untouched.
      state_d = S_IDLE;
      tmr_d   = tmr_q + TMR_ONE;
      fe_d    = 1'b1;
    end else begin
      // Count every stalled clock, including clocks where hold is high.
      tmr_d = tmr_q + TMR_ONE;
    end
  end

  // Control registers: FSM state, timer, and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ready_q <= ~hold;
    end
  end

  // Data registers: shadow bytes, committed readings, frame counter, status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd1_q  <= 8'h00;
      shd2_q  <= 8'h00;
      shd3_q  <= 8'h00;
      shd4_q  <= 8'h00;
      sens1_q <= 8'h00;
      sens2_q <= 8'h00;
      sens3_q <= 8'h00;
      sens4_q <= 8'h00;
      cnt_q   <= 8'h00;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      shd1_q  <= shd1_d;
      shd2_q  <= shd2_d;
      shd3_q  <= shd3_d;
      shd4_q  <= shd4_d;
      sens1_q <= sens1_d;
      sens2_q <= sens2_d;
      sens3_q <= sens3_d;
      sens4_q <= sens4_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_ready  = ready_q;
  assign sensor1     = sens1_q;
  assign sensor2     = sens2_q;
  assign sensor3     = sens3_q;
  assign sensor4     = sens4_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign frame_cnt   = cnt_q;

endmodule
`default_nettype wire
